data_mem_responder: RTL

Memory-side responder for the CPU's data-RAM port. It accepts the CPU's read and write strobes together with address, byte-select and store data, and applies a parameterised number of wait states. It then performs a word-array access with byte-lane writes and returns load data, and it asserts a stall back to the CPU while the access is in flight. It also flags misaligned, out-of-range and conflicting requests.

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-RAM responder: wait-stated word array with byte-lane stores,
// registered load data, CPU stall and one-cycle address-error pulse.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   i_ramReadEnable    - load request
//   i_ramWriteEnable   - store request
//   i_ramAddr[31:0]    - byte address (word aligned, in range)
//   i_ramSel[3:0]      - store byte enables, bit 3 = data[31:24]
//   i_ramStoreData     - lane-aligned store data
//   o_ramLoadData      - registered load data, updated on read completion
//   o_stall            - access in flight, CPU holds its inputs
//   o_addrError        - one-cycle pulse after an illegal request
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ramReadEnable,
    input  logic        i_ramWriteEnable,
    input  logic [31:0] i_ramAddr,
    input  logic [3:0]  i_ramSel,
    input  logic [31:0] i_ramStoreData,
    output logic [31:0] o_ramLoadData,
    output logic        o_stall,
    output logic        o_addrError
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] cnt;

    logic                  lat_wr;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [3:0]            lat_sel;
    logic [31:0]           lat_data;

    logic [31:0] mem [DEPTH];

    logic req;
    logic legal;
    logic accept;
    logic reject;
    logic commit;

    always_comb begin
        req    = i_ramReadEnable | i_ramWriteEnable;
        legal  = !(i_ramReadEnable && i_ramWriteEnable)
              && (i_ramAddr[1:0] == 2'b00)
              && (i_ramAddr[31:DEPTH_LOG2+2] == '0);
        accept    = 1'b0;
        reject    = 1'b0;
        commit    = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (legal) begin
                        accept    = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            // Whatever request is still present here is the tail of the
            // one just served, so it is not looked at.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        o_stall = accept || (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            o_ramLoadData <= 32'd0;
            o_addrError   <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_addrError <= reject;
            if (accept) begin
                cnt <= WAIT_CNT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !lat_wr) begin
                o_ramLoadData <= mem[lat_idx];
            end
        end
    end

    // Request is captured once at acceptance; later input wiggles
    // during BUSY cannot disturb the access in flight.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lat_wr   <= i_ramWriteEnable;
            lat_idx  <= i_ramAddr[DEPTH_LOG2+1:2];
            lat_sel  <= i_ramSel;
            lat_data <= i_ramStoreData;
        end
    end

    // Array is never cleared; a reset landing on the commit edge drops
    // the store so memory keeps its prior contents.
    always_ff @(posedge clk) begin
        if (!rst && commit && lat_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_sel[b]) begin
                    mem[lat_idx][8*b +: 8] <= lat_data[8*b +: 8];
                end
            end
        end
    end

endmodule
